// File: rtl/vc_arbiter.sv
// Weighted round-robin arbiter moving head words from two virtual-channel FIFOs
// into the D0/D1 destination FIFOs, with a one-cycle pop-to-push latency.
module vc_arbiter #(
    parameter int BITNUMBER = 6,
    parameter int DEST_BIT  = 4,
    parameter int W0        = 3,
    parameter int W1        = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 active,
    input  logic                 VC0_empty,
    input  logic                 VC1_empty,
    input  logic [BITNUMBER-1:0] VC0_data,
    input  logic [BITNUMBER-1:0] VC1_data,
    input  logic                 D0_almost_full,
    input  logic                 D1_almost_full,
    output logic                 pop_VC0,
    output logic                 pop_VC1,
    output logic                 push_D0,
    output logic                 push_D1,
    output logic [BITNUMBER-1:0] data_out,
    output logic [1:0]           arb_state
);

    localparam int WMAX  = (W0 > W1) ? W0 : W1;
    localparam int CNT_W = $clog2(WMAX) + 1;
    localparam logic [CNT_W-1:0] W0_C  = CNT_W'(W0);
    localparam logic [CNT_W-1:0] W1_C  = CNT_W'(W1);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } arb_state_e;

    arb_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic [BITNUMBER-1:0] data_q, data_d;
    logic                 push0_q, push0_d;
    logic                 push1_q, push1_d;

    logic vc0_dest, vc1_dest;
    logic vc0_ok, vc1_ok;
    logic grant0, grant1;

    // Reset is folded into eligibility so no pop escapes while reset is low.
    assign vc0_dest = VC0_data[DEST_BIT];
    assign vc1_dest = VC1_data[DEST_BIT];
    assign vc0_ok   = reset & active & ~VC0_empty & ~(vc0_dest ? D1_almost_full : D0_almost_full);
    assign vc1_ok   = reset & active & ~VC1_empty & ~(vc1_dest ? D1_almost_full : D0_almost_full);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        grant0  = 1'b0;
        grant1  = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        data_d  = data_q;
        push0_d = 1'b0;
        push1_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (vc0_ok && vc1_ok) begin
                    grant0 = last_q;
                    grant1 = ~last_q;
                end else begin
                    grant0 = vc0_ok;
                    grant1 = vc1_ok;
                end
            end
            SERVE0: begin
                if (vc0_ok && (cnt_q < W0_C || !vc1_ok))
                    grant0 = 1'b1;
                else if (vc1_ok && (cnt_q == W0_C || !vc0_ok))
                    grant1 = 1'b1;
            end
            SERVE1: begin
                if (vc1_ok && (cnt_q < W1_C || !vc0_ok))
                    grant1 = 1'b1;
                else if (vc0_ok && (cnt_q == W1_C || !vc1_ok))
                    grant0 = 1'b1;
            end
            default: ;
        endcase

        if (grant0) begin
            state_d = SERVE0;
            cnt_d   = (state_q != SERVE0) ? ONE_C : (cnt_q < W0_C) ? cnt_q + ONE_C : cnt_q;
            last_d  = 1'b0;
            data_d  = VC0_data;
            push0_d = ~vc0_dest;
            push1_d = vc0_dest;
        end else if (grant1) begin
            state_d = SERVE1;
            cnt_d   = (state_q != SERVE1) ? ONE_C : (cnt_q < W1_C) ? cnt_q + ONE_C : cnt_q;
            last_d  = 1'b1;
            data_d  = VC1_data;
            push0_d = ~vc1_dest;
            push1_d = vc1_dest;
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            data_q  <= '0;
            push0_q <= 1'b0;
            push1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
            push0_q <= push0_d;
            push1_q <= push1_d;
        end
    end

    assign pop_VC0   = grant0;
    assign pop_VC1   = grant1;
    assign push_D0   = push0_q;
    assign push_D1   = push1_q;
    assign data_out  = data_q;
    assign arb_state = state_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter: small VC FIFO model, hand-computed grant,
// push and state sequences checked with immediate assertions each cycle.
module tb_vc_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       active;
    logic       VC0_empty, VC1_empty;
    logic [5:0] VC0_data, VC1_data;
    logic       D0_almost_full, D1_almost_full;
    logic       pop_VC0, pop_VC1;
    logic       push_D0, push_D1;
    logic [5:0] data_out;
    logic [1:0] arb_state;

    vc_arbiter #(
        .BITNUMBER(6),
        .DEST_BIT (4),
        .W0       (3),
        .W1       (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .active        (active),
        .VC0_empty     (VC0_empty),
        .VC1_empty     (VC1_empty),
        .VC0_data      (VC0_data),
        .VC1_data      (VC1_data),
        .D0_almost_full(D0_almost_full),
        .D1_almost_full(D1_almost_full),
        .pop_VC0       (pop_VC0),
        .pop_VC1       (pop_VC1),
        .push_D0       (push_D0),
        .push_D1       (push_D1),
        .data_out      (data_out),
        .arb_state     (arb_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [5:0] mem0 [32];
    logic [5:0] mem1 [32];
    int rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        VC0_empty = (rd0 == wr0);
        VC1_empty = (rd1 == wr1);
        VC0_data  = VC0_empty ? 6'h00 : mem0[rd0];
        VC1_data  = VC1_empty ? 6'h00 : mem1[rd1];
    endtask

    task automatic load0(input logic [5:0] w);
        mem0[wr0] = w;
        wr0++;
        drive();
    endtask

    task automatic load1(input logic [5:0] w);
        mem1[wr1] = w;
        wr1++;
        drive();
    endtask

    // One clock cycle: pops checked before the edge, registered outputs after it.
    task automatic step(input string tag, input logic e_pop0, input logic e_pop1,
                        input logic e_push0, input logic e_push1,
                        input logic [5:0] e_data, input logic [1:0] e_state);
        logic p0, p1;
        drive();
        #1;
        check({tag, "_pop0"}, pop_VC0, e_pop0);
        check({tag, "_pop1"}, pop_VC1, e_pop1);
        p0 = pop_VC0;
        p1 = pop_VC1;
        @(posedge clk);
        if (p0 === 1'b1) rd0++;
        if (p1 === 1'b1) rd1++;
        #1;
        check({tag, "_push0"}, push_D0, e_push0);
        check({tag, "_push1"}, push_D1, e_push1);
        check({tag, "_data"}, data_out, e_data);
        check({tag, "_state"}, arb_state, e_state);
        drive();
    endtask

    logic [5:0] t1_data [16] = '{6'h01, 6'h02, 6'h03, 6'h21, 6'h04, 6'h05, 6'h06, 6'h22,
                                 6'h07, 6'h08, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h28};
    logic       t1_sel  [16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        reset          = 1'b0;
        active         = 1'b1;
        D0_almost_full = 1'b0;
        D1_almost_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            load0(6'h01 + 6'(i));
            load1(6'h21 + 6'(i));
        end

        // Reset with traffic waiting: pops gated, registers cleared.
        step("rst0", 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 2'd0);
        step("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 2'd0);
        reset = 1'b1;

        // Weighted 3:1 interleave, then VC1 drains alone once VC0 runs dry.
        for (int i = 0; i < 16; i++)
            step($sformatf("wrr%0d", i), !t1_sel[i], t1_sel[i], 1'b1, 1'b0,
                 t1_data[i], t1_sel[i] ? 2'd2 : 2'd1);

        // Both VCs empty: IDLE, push strobes low, data_out holds.
        for (int i = 0; i < 5; i++)
            step($sformatf("empty%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 6'h28, 2'd0);

        // Only VC1, alternating destinations.
        load1(6'h01); load1(6'h11); load1(6'h02); load1(6'h12);
        step("alt0", 1'b0, 1'b1, 1'b1, 1'b0, 6'h01, 2'd2);
        step("alt1", 1'b0, 1'b1, 1'b0, 1'b1, 6'h11, 2'd2);
        step("alt2", 1'b0, 1'b1, 1'b1, 1'b0, 6'h02, 2'd2);
        step("alt3", 1'b0, 1'b1, 1'b0, 1'b1, 6'h12, 2'd2);
        step("alt_idle", 1'b0, 1'b0, 1'b0, 1'b0, 6'h12, 2'd0);

        // VC0 blocked on D1 almost full; VC1 keeps flowing; VC0 resumes at once.
        D1_almost_full = 1'b1;
        load0(6'h13);
        load1(6'h03); load1(6'h04); load1(6'h05);
        step("hol0", 1'b0, 1'b1, 1'b1, 1'b0, 6'h03, 2'd2);
        step("hol1", 1'b0, 1'b1, 1'b1, 1'b0, 6'h04, 2'd2);
        D1_almost_full = 1'b0;
        step("hol_resume", 1'b1, 1'b0, 1'b0, 1'b1, 6'h13, 2'd1);
        step("hol3", 1'b0, 1'b1, 1'b1, 1'b0, 6'h05, 2'd2);
        step("hol_idle", 1'b0, 1'b0, 1'b0, 1'b0, 6'h05, 2'd0);

        // active drops for 3 cycles mid-stream; the in-flight push already showed above.
        load0(6'h06); load0(6'h07);
        step("act_on", 1'b1, 1'b0, 1'b1, 1'b0, 6'h06, 2'd1);
        active = 1'b0;
        for (int i = 0; i < 3; i++)
            step($sformatf("act_off%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 6'h06, 2'd0);
        active = 1'b1;
        step("act_back", 1'b1, 1'b0, 1'b1, 1'b0, 6'h07, 2'd1);
        step("act_idle", 1'b0, 1'b0, 1'b0, 1'b0, 6'h07, 2'd0);

        // Reset in SERVE0 with cnt=2; afterwards VC0 is preferred again.
        load0(6'h0A); load0(6'h0B); load0(6'h0C); load0(6'h0D);
        step("srv0_a", 1'b1, 1'b0, 1'b1, 1'b0, 6'h0A, 2'd1);
        step("srv0_b", 1'b1, 1'b0, 1'b1, 1'b0, 6'h0B, 2'd1);
        load1(6'h2A); load1(6'h2B);
        reset = 1'b0;
        step("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 2'd0);
        reset = 1'b1;
        step("post_rst0", 1'b1, 1'b0, 1'b1, 1'b0, 6'h0C, 2'd1);
        step("post_rst1", 1'b1, 1'b0, 1'b1, 1'b0, 6'h0D, 2'd1);
        step("post_rst2", 1'b0, 1'b1, 1'b1, 1'b0, 6'h2A, 2'd2);
        step("post_rst3", 1'b0, 1'b1, 1'b1, 1'b0, 6'h2B, 2'd2);
        step("post_idle", 1'b0, 1'b0, 1'b0, 1'b0, 6'h2B, 2'd0);

        // D0 almost full blocks the D0-bound VC0 head; VC1 to D1 proceeds.
        D0_almost_full = 1'b1;
        load0(6'h0E);
        load1(6'h1E);
        step("d0af0", 1'b0, 1'b1, 1'b0, 1'b1, 6'h1E, 2'd2);
        step("d0af1", 1'b0, 1'b0, 1'b0, 1'b0, 6'h1E, 2'd0);
        D0_almost_full = 1'b0;
        step("d0af2", 1'b1, 1'b0, 1'b1, 1'b0, 6'h0E, 2'd1);
        step("d0af3", 1'b0, 1'b0, 1'b0, 1'b0, 6'h0E, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vc_arbiter.md
# vc_arbiter

Weighted round-robin arbiter that moves words from the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1) of the PCIe transaction layer. Each cycle it picks at most one VC head word, pops it, and pushes it one cycle later into the destination FIFO selected by the word's destination bit. Head-of-line blocking on one destination does not stall the other VC. It sits between the VC FIFO stage and the D0/D1 FIFOs, and is enabled only while the main transaction FSM is ACTIVE.

## Interface
- BITNUMBER, 6, word width.
- DEST_BIT, 4, bit index of the destination select (0 → D0, 1 → D1).
- W0, 3, maximum consecutive grants to VC0 while VC1 is eligible (≥1).
- W1, 1, maximum consecutive grants to VC1 while VC0 is eligible (≥1).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- active  in  1  arbitration enable; high only while the main FSM is in ACTIVE.
- VC0_empty, VC1_empty  in  1  VC FIFO empty flags.
- VC0_data, VC1_data  in  BITNUMBER  VC FIFO head words (first-word-fall-through; valid whenever not empty).
- D0_almost_full, D1_almost_full  in  1  high when the destination FIFO has ≤1 free entry.
- pop_VC0, pop_VC1  out  1  combinational pop strobes, same cycle as grant.
- push_D0, push_D1  out  1  registered push strobes.
- data_out  out  BITNUMBER  registered word for D0/D1.
- arb_state  out  2  current state: 0 IDLE, 1 SERVE0, 2 SERVE1.

## Operation
- Eligibility: VCi_ok = active & !VCi_empty & !D[VCi_data[DEST_BIT]]_almost_full.
- Registers: arb_state, grant counter cnt (width ≥ clog2(max(W0,W1))+1), last_served bit, data_out, push_D0/push_D1.
- IDLE:
  - If both VCs are eligible, grant the VC that is not last_served.
  - Otherwise grant whichever VC is eligible.
  - If neither is eligible, stay in IDLE.
  - A grant sets cnt=1 and moves to SERVEi.
- SERVE0:
  - VC0_ok & (cnt<W0 | !VC1_ok) → grant VC0; cnt saturates at W0.
  - VC1_ok & (cnt==W0 | !VC0_ok) → grant VC1, go to SERVE1, cnt=1.
  - Neither eligible → IDLE, cnt=0.
- SERVE1: symmetric, using W1.
- A grant to VCi in cycle n:
  - pop_VCi=1 in cycle n.
  - data_out←VCi_data and push_D[VCi_data[DEST_BIT]]←1 at edge n+1.
  - last_served←i.
- At most one pop and at most one push per cycle; pop_VC0 and pop_VC1 are never high together.
- Cycles without a grant drive both push strobes low at the next edge. data_out holds its last value.
- active low: no grants, state goes to IDLE, cnt=0. A push already in flight still completes.
- The almost_full threshold (≤1 free) covers the one in-flight word, so no destination overflow occurs.
- Reset (reset=0 at an edge):
  - arb_state=IDLE, cnt=0, last_served=1 (VC0 preferred first), data_out=0, push_D0=push_D1=0.
  - Pops are gated low combinationally while reset=0.
  - A word popped in the cycle before reset is dropped; the VC and D FIFOs are reset by the same signal.

## Timing
- Pop-to-push latency is exactly 1 cycle.
- Sustained throughput is 1 word/cycle when any VC is eligible.
- Pops depend combinationally on the empty flags, almost_full flags, head data and active, but not on push/pop outputs, so there is no combinational loop.
- Arbitration switching costs 0 bubble cycles.
- Almost_full rising in cycle n blocks grants to that destination from cycle n onward.

## Test plan
- Reset, then both VCs loaded with 8 words to D0, W0=3, W1=1 → pop order VC0×3, VC1×1, repeating. push_D0 follows each pop by 1 cycle with matching data_out. No bubbles.
- Only VC1 non-empty, 4 words alternating DEST_BIT 0/1 → 4 consecutive pop_VC1. push_D0, push_D1, push_D0, push_D1 in cycles n+1..n+4.
- VC0 head targets D1 with D1_almost_full=1, VC1 head targets D0 → only VC1 is popped while VC0 is held. Deasserting D1_almost_full resumes VC0 in the same cycle.
- Mid-stream active=0 for 3 cycles → no pops in those cycles. The pending push completes one cycle after active falls. arb_state=0. Arbitration resumes on the first cycle active=1.
- reset=0 asserted during SERVE0 with cnt=2 → next edge: arb_state=0, push strobes 0, data_out=0. First grant after release goes to VC0 when both are eligible.
- Both VCs empty for 5 cycles after traffic → arb_state=IDLE. push_D0/push_D1 are low from the cycle after the last grant.
